control_merge: RTL and testbench
================================

Name: control_merge

Overview:
- Dataflow control-merge stage that feeds a dataflow mux.
- Accepts one token from any of SIZE input channels and forwards its data on `outs`.
- Emits the winning channel number on `index`; that output drives the mux select channel downstream.
- Both outputs go through an internal one-slot transparent elastic buffer (TEHB) and an eager 2-way fork, so each output completes its handshake independently.

Parameters:
- SIZE, 2, number of input channels (>=2)
- DATA_TYPE, 32, data width in bits (>=1)
- INDEX_TYPE, 1, index width in bits; must satisfy 2**INDEX_TYPE >= SIZE

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- ins  input  SIZE*DATA_TYPE  packed input data; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE]
- ins_valid  input  SIZE  per-channel valid
- ins_ready  output  SIZE  per-channel ready
- outs  output  DATA_TYPE  merged data
- outs_valid  output  1  data valid
- outs_ready  input  1  data ready
- index  output  INDEX_TYPE  winning channel number
- index_valid  output  1  index valid
- index_ready  input  1  index ready

Behaviour:
- Reset
  - rst is synchronous, active-high.
  - rst clears: TEHB full flag, TEHB data/index registers (to 0), fork sent_outs/sent_index flags.
  - While rst=1, ins_ready, outs_valid and index_valid are forced to 0.
- Arbitration (combinational, fixed priority)
  - any_valid = OR of ins_valid.
  - Winner w = lowest i with ins_valid[i]=1.
  - ins_ready[i] = (i==w) & any_valid & tehb_ready.
  - Non-winning valid channels are held, never dropped.
- TEHB (one slot, zero latency when empty)
  - tehb_ready = ~full.
  - Output pair = full ? {reg_data, reg_idx} : {ins[w], w}.
  - tehb_valid = full | any_valid.
  - Fill: full <= 1, capturing the winner pair, when any_valid & ~full & ~fork_ready.
  - Drain: full <= 0 when full & fork_ready.
  - While full, no new input is accepted. The buffered token is always emitted before any new token.
- Eager fork
  - outs_valid = tehb_valid & ~sent_outs.
  - index_valid = tehb_valid & ~sent_index.
  - fork_ready = (sent_outs | outs_ready) & (sent_index | index_ready).
  - If tehb_valid & fork_ready: both sent flags <= 0 (token retired).
  - Else: sent_x <= sent_x | (x_valid & x_ready).
  - Each output handshakes exactly once per token.
  - Both outputs ready in the same cycle as arrival: throughput 1 token/cycle, latency 0.
- Outputs hold stable data while valid & ~ready (elastic protocol).
- Reset mid-token: token and partial fork state are discarded; first post-reset cycle behaves as empty.

Optional Feature:
- Macro: CONTROL_MERGE_ROUND_ROBIN_EN.
- Defined:
  - Adds register last_grant (INDEX_TYPE bits, reset to SIZE-1).
  - Search starts at (last_grant+1) mod SIZE and wraps around; w is the first valid channel found.
  - last_grant <= w on every accepted input handshake (ins_valid[w] & ins_ready[w]); unchanged otherwise.
- Undefined: fixed lowest-index priority as above; no extra register.

Decomposition:
- Shared package/header: handshake channel width helpers, INDEX_TYPE sizing function (clog2 with minimum 1), reset polarity constant.
- Natural sub-module: the existing tehb instantiated with DATA_TYPE+INDEX_TYPE width for the buffer.
- New sub-module eager_fork_2 holds the two sent flags and fork logic; arbiter stays inline.

Test Plan:
- Single channel: SIZE=2, ins_valid=2'b10, ch1 data 0xAB, both readies 1 -> same cycle outs=0xAB, index=1, both valid=1, ins_ready=2'b10.
- Contention: ins_valid=2'b11 (data 0x11/0x22), readies 1 -> cycle0 index=0/outs=0x11, ins_ready=2'b01; after ch0 drops, cycle1 index=1/outs=0x22.
- Partial fork: outs_ready=0, index_ready=1, token ch1 -> index_valid pulses one cycle then 0; outs_valid held with stable data; outs_ready=1 later -> token retires, no second index handshake.
- Backpressure: both readies 0, ch0 token 0x55 -> TEHB fills, ins_ready=0 next cycle; new ch1 token waits; readies 1 -> 0x55/index0 emitted first, then ch1.
- Reset mid-operation: sent_index=1 and full=1, assert rst one cycle -> valids/readies 0 during rst; afterwards empty; fresh token handshaked on both outputs.
- CONTROL_MERGE_ROUND_ROBIN_EN, SIZE=3, all valid continuously, readies 1 -> index sequence 0,1,2,0,1; with macro undefined -> 0,0,0.

Source files
------------

// File: rtl/control_merge_pkg.sv
// Shared helpers for the control_merge slice: reset polarity, channel sizing and fork port names.
package control_merge_pkg;

  localparam logic RstActive = 1'b1;

  typedef enum logic {
    OutData  = 1'b0,
    OutIndex = 1'b1
  } fork_port_e;

  // Index width needed to name n channels; never narrower than one bit.
  function automatic int unsigned index_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned packed_width(int unsigned size, int unsigned width);
    return size * width;
  endfunction

endpackage

// File: rtl/control_merge_eager_fork_2.sv
// Eager 2-way fork: each branch handshakes once per token; the token retires when both are done.
module control_merge_eager_fork_2
  import control_merge_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [1:0] out_valid_o,
  input  logic [1:0] out_ready_i
);

  logic [1:0] sent_q, sent_d;

  assign out_valid_o = {2{in_valid_i}} & ~sent_q;
  assign in_ready_o  = &(sent_q | out_ready_i);

  always_comb begin
    if (in_valid_i && in_ready_o) begin
      sent_d = '0;
    end else begin
      sent_d = sent_q | (out_valid_o & out_ready_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstActive) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

// File: rtl/control_merge_tehb.sv
// One-slot transparent elastic buffer: zero latency when empty, holds one token under backpressure.
module control_merge_tehb
  import control_merge_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q && out_ready_i) begin
      full_d = 1'b0;
    end else if (!full_q && in_valid_i && !out_ready_i) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstActive) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready_o  = ~full_q;
  assign out_valid_o = full_q | in_valid_i;
  assign out_data_o  = full_q ? data_q : in_data_i;

endmodule

// File: rtl/control_merge.sv
// Dataflow control-merge: picks one valid input channel, forwards data and winning index.
// Define CONTROL_MERGE_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module control_merge
  import control_merge_pkg::*;
#(
  parameter int unsigned SIZE       = 2,
  parameter int unsigned DATA_TYPE  = 32,
  parameter int unsigned INDEX_TYPE = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [packed_width(SIZE, DATA_TYPE)-1:0]  ins,
  input  logic [SIZE-1:0]                           ins_valid,
  output logic [SIZE-1:0]                           ins_ready,
  output logic [DATA_TYPE-1:0]                      outs,
  output logic                                      outs_valid,
  input  logic                                      outs_ready,
  output logic [INDEX_TYPE-1:0]                     index,
  output logic                                      index_valid,
  input  logic                                      index_ready
);

  localparam int unsigned TehbWidth = DATA_TYPE + INDEX_TYPE;

  logic                  any_valid;
  logic [INDEX_TYPE-1:0] win_idx;
  logic [DATA_TYPE-1:0]  win_data;
  int unsigned           start;
  int unsigned           cand;
  logic [SIZE-1:0]       vshift;

  logic                  tehb_ready;
  logic                  tehb_valid;
  logic [TehbWidth-1:0]  tehb_out;
  logic                  fork_ready;
  logic [1:0]            fork_valid;
  logic                  in_reset;

  assign in_reset = (rst == RstActive);

`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
  logic [INDEX_TYPE-1:0] last_grant_q, last_grant_d;

  always_comb begin
    if (32'(last_grant_q) + 1 >= SIZE) begin
      start = 0;
    end else begin
      start = 32'(last_grant_q) + 1;
    end
  end

  assign last_grant_d = (any_valid && tehb_ready) ? win_idx : last_grant_q;

  always_ff @(posedge clk) begin
    if (in_reset) begin
      last_grant_q <= INDEX_TYPE'(SIZE - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign start = 0;
`endif

  // Scan channels starting at 'start', wrapping; the first valid one wins.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    cand      = 0;
    vshift    = '0;
    for (int unsigned k = 0; k < SIZE; k++) begin
      cand = start + k;
      if (cand >= SIZE) begin
        cand = cand - SIZE;
      end
      vshift = ins_valid >> cand;
      if (!any_valid && vshift[0]) begin
        any_valid = 1'b1;
        win_idx   = INDEX_TYPE'(cand);
        win_data  = DATA_TYPE'(ins >> (cand * DATA_TYPE));
      end
    end
  end

  always_comb begin
    ins_ready = '0;
    if (!in_reset && any_valid && tehb_ready) begin
      ins_ready = SIZE'(1) << win_idx;
    end
  end

  control_merge_tehb #(
    .Width(TehbWidth)
  ) u_tehb (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  ({win_data, win_idx}),
    .in_valid_i (any_valid),
    .in_ready_o (tehb_ready),
    .out_data_o (tehb_out),
    .out_valid_o(tehb_valid),
    .out_ready_i(fork_ready)
  );

  control_merge_eager_fork_2 u_fork (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (tehb_valid),
    .in_ready_o (fork_ready),
    .out_valid_o(fork_valid),
    .out_ready_i({index_ready, outs_ready})
  );

  assign outs        = tehb_out[TehbWidth-1 -: DATA_TYPE];
  assign index       = tehb_out[INDEX_TYPE-1:0];
  assign outs_valid  = fork_valid[OutData] & ~in_reset;
  assign index_valid = fork_valid[OutIndex] & ~in_reset;

endmodule

// File: tb/tb_control_merge.sv
// Bench for control_merge (SIZE=3): token-level model checked every cycle plus directed literals.
module tb_control_merge;
  import control_merge_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = index_width(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] ins = '0;
  logic [N-1:0]    ins_valid = '0;
  logic [N-1:0]    ins_ready;
  logic [DW-1:0]   outs;
  logic            outs_valid;
  logic            outs_ready = 1'b0;
  logic [IW-1:0]   index;
  logic            index_valid;
  logic            index_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_merge #(
    .SIZE      (N),
    .DATA_TYPE (DW),
    .INDEX_TYPE(IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .index      (index),
    .index_valid(index_valid),
    .index_ready(index_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule: which channel is granted given the valids and the previous grant.
  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (last + k) % int'(N);
      if (v[c]) return c;
    end
`else
    for (int c = 0; c < int'(N); c++) begin
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  // Token model: at most one parked token, plus which outputs already took the current token.
  bit          m_full = 0, n_full = 0;
  logic [31:0] m_data = '0, n_data = '0;
  int          m_idx = 0, n_idx = 0;
  bit          m_otaken = 0, n_otaken = 0;
  bit          m_itaken = 0, n_itaken = 0;
  int          m_last = N - 1, n_last = N - 1;

  always @(negedge clk) begin
    int          win;
    bit          have, o_done, i_done;
    logic [31:0] h_data;
    int          h_idx;
    logic [N-1:0] exp_rdy;
    if (rst) begin
      check("cmp_rst_ins_ready", 32'(ins_ready), 32'h0);
      check("cmp_rst_outs_valid", 32'(outs_valid), 32'h0);
      check("cmp_rst_index_valid", 32'(index_valid), 32'h0);
      n_full = 0; n_otaken = 0; n_itaken = 0; n_last = N - 1;
      n_data = m_data; n_idx = m_idx;
    end else begin
      win     = pick(ins_valid, m_last);
      have    = m_full || (win >= 0);
      h_data  = m_full ? m_data : ((win >= 0) ? ins[win*DW +: DW] : 32'h0);
      h_idx   = m_full ? m_idx : win;
      exp_rdy = (!m_full && win >= 0) ? N'(1) << win : '0;
      check("cmp_ins_ready", 32'(ins_ready), 32'(exp_rdy));
      check("cmp_outs_valid", 32'(outs_valid), 32'(have && !m_otaken));
      check("cmp_index_valid", 32'(index_valid), 32'(have && !m_itaken));
      if (have && !m_otaken) check("cmp_outs", outs, h_data);
      if (have && !m_itaken) check("cmp_index", 32'(index), 32'(h_idx));
      o_done = m_otaken || (have && outs_ready);
      i_done = m_itaken || (have && index_ready);
      n_full = m_full; n_data = m_data; n_idx = m_idx;
      n_otaken = m_otaken; n_itaken = m_itaken; n_last = m_last;
      if (have) begin
        if (o_done && i_done) begin
          n_full = 0; n_otaken = 0; n_itaken = 0;
        end else begin
          n_full = 1; n_data = h_data; n_idx = h_idx;
          n_otaken = o_done; n_itaken = i_done;
        end
      end
      if (!m_full && win >= 0) n_last = win;
    end
  end

  always @(posedge clk) begin
    m_full = n_full; m_data = n_data; m_idx = n_idx;
    m_otaken = n_otaken; m_itaken = n_itaken; m_last = n_last;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic ordy, input logic irdy);
    ins_valid   = v;
    ins         = {d2, d1, d0};
    outs_ready  = ordy;
    index_ready = irdy;
  endtask

  int rr_exp [5];

  initial begin
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
    rr_exp = '{0, 1, 2, 0, 1};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif
    // Reset forces handshake outputs low even with valid inputs.
    next_cycle();
    drive(3'b011, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1);
    #1;
    check("rst_ins_ready", 32'(ins_ready), 32'h0);
    check("rst_outs_valid", 32'(outs_valid), 32'h0);
    check("rst_index_valid", 32'(index_valid), 32'h0);

    // Single channel, zero latency.
    next_cycle();
    rst = 1'b0;
    drive(3'b010, 32'h0, 32'hAB, 32'h0, 1'b1, 1'b1);
    #1;
    check("single_outs", outs, 32'hAB);
    check("single_index", 32'(index), 32'd1);
    check("single_valids", {30'h0, outs_valid, index_valid}, 32'h3);
    check("single_ins_ready", 32'(ins_ready), 32'h2);

    // Contention: channel 0 first, channel 1 held until 0 drops.
    next_cycle();
    drive(3'b011, 32'h11, 32'h22, 32'h0, 1'b1, 1'b1);
    #1;
    check("cont0_index", 32'(index), 32'd0);
    check("cont0_outs", outs, 32'h11);
    check("cont0_ins_ready", 32'(ins_ready), 32'h1);
    next_cycle();
    drive(3'b010, 32'h11, 32'h22, 32'h0, 1'b1, 1'b1);
    #1;
    check("cont1_index", 32'(index), 32'd1);
    check("cont1_outs", outs, 32'h22);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);

    // Partial fork: index taken at once, data held until outs_ready.
    next_cycle();
    drive(3'b010, 32'h0, 32'h33, 32'h0, 1'b0, 1'b1);
    #1;
    check("pf_index_valid0", 32'(index_valid), 32'h1);
    check("pf_outs_valid0", 32'(outs_valid), 32'h1);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("pf_index_valid1", 32'(index_valid), 32'h0);
    check("pf_outs_hold1", outs, 32'h33);
    check("pf_ins_ready1", 32'(ins_ready), 32'h0);
    next_cycle();
    #1;
    check("pf_outs_hold2", outs, 32'h33);
    check("pf_outs_valid2", 32'(outs_valid), 32'h1);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check("pf_outs_valid3", 32'(outs_valid), 32'h1);
    check("pf_index_valid3", 32'(index_valid), 32'h0);
    next_cycle();
    #1;
    check("pf_retired", {30'h0, outs_valid, index_valid}, 32'h0);

    // Backpressure: 0x55 parks in the buffer and drains before channel 1.
    next_cycle();
    drive(3'b001, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("bp_ins_ready0", 32'(ins_ready), 32'h1);
    next_cycle();
    drive(3'b010, 32'h0, 32'h66, 32'h0, 1'b0, 1'b0);
    #1;
    check("bp_ins_ready1", 32'(ins_ready), 32'h0);
    check("bp_outs1", outs, 32'h55);
    next_cycle();
    drive(3'b010, 32'h0, 32'h66, 32'h0, 1'b1, 1'b1);
    #1;
    check("bp_outs2", outs, 32'h55);
    check("bp_index2", 32'(index), 32'd0);
    check("bp_ins_ready2", 32'(ins_ready), 32'h0);
    next_cycle();
    #1;
    check("bp_outs3", outs, 32'h66);
    check("bp_index3", 32'(index), 32'd1);
    check("bp_ins_ready3", 32'(ins_ready), 32'h2);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);

    // Reset with a parked, half-sent token.
    next_cycle();
    drive(3'b100, 32'h0, 32'h0, 32'h77, 1'b0, 1'b1);
    #1;
    check("rm_ins_ready0", 32'(ins_ready), 32'h4);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("rm_parked", {30'h0, outs_valid, index_valid}, 32'h2);
    check("rm_outs", outs, 32'h77);
    next_cycle();
    rst = 1'b1;
    drive(3'b001, 32'h88, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check("rm_rst_valids", {30'h0, outs_valid, index_valid}, 32'h0);
    check("rm_rst_ins_ready", 32'(ins_ready), 32'h0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rm_post_ins_ready", 32'(ins_ready), 32'h1);
    check("rm_post_valids", {30'h0, outs_valid, index_valid}, 32'h3);
    check("rm_post_outs", outs, 32'h88);
    check("rm_post_index", 32'(index), 32'd0);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);

    // Arbitration order with all channels valid, from a fresh reset.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(3'b111, 32'hC0, 32'hC1, 32'hC2, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("arb_index", 32'(index), 32'(rr_exp[k]));
      check("arb_outs", outs, 32'hC0 + 32'(rr_exp[k]));
      next_cycle();
    end
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
